zero_cross_freq_estimator: RTL

Estimates the fundamental frequency of the incoming audio sample stream and presents it as an integer in Hz, feeding the frequency-to-note classifier directly. It detects rising zero crossings with a hysteresis (Schmitt) comparator and counts samples across a fixed number of whole periods. It then converts that count to Hz with a sequential rounding divider. It sits between the audio front end (ADC/decimator output) and note classification.

---
 rtl/zero_cross_freq_estimator.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/zero_cross_freq_estimator.sv
// Zero-crossing frequency estimator: Schmitt-trigger rising-edge detector, sample-count window
// over PERIODS whole periods, and a sequential rounding divider that converts the count to Hz.
//   window state | meaning
//   W_SEEK       | waiting for the first rising crossing (samples still counted for timeout)
//   W_COUNT      | counting samples across PERIODS periods
//   div state    | meaning
//   D_IDLE       | waiting for a window handoff
//   D_BUSY       | restoring division, one quotient bit per cycle
//   D_DONE       | register saturated quotient to the outputs
module zero_cross_freq_estimator #(
    parameter int unsigned SAMPLE_HZ = 48000,
    parameter int unsigned PERIODS   = 4,
    parameter int unsigned HYST      = 64,
    parameter int unsigned MAX_COUNT = 4095,
    parameter int unsigned DIV_W     = 32
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid_in,
    output logic        [15:0] frequency_out,
    output logic               freq_valid_out,
    output logic               locked_out
);

    typedef enum logic {W_SEEK, W_COUNT} win_t;
    typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} div_t;

    localparam int unsigned STEP_W = $clog2(DIV_W);
    localparam logic signed [16:0] HYST_HI = 17'(HYST);
    localparam logic signed [16:0] HYST_LO = -HYST_HI;
    localparam logic [4:0] PCNT_LAST = 5'(PERIODS - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_W - 1);
    localparam logic [DIV_W-1:0] DIVIDEND_BASE = DIV_W'(SAMPLE_HZ * PERIODS);

    win_t win_q, win_next;
    div_t div_q, div_next;

    logic               level_q, level_next;
    logic signed [16:0] sample_x;
    logic               level_set, level_clr, rising;
    logic [15:0]        cnt_q, cnt_next;
    logic [16:0]        cnt_inc;
    logic               over;
    logic [4:0]         pcnt_q, pcnt_next;
    logic               handoff, handoff_q, timeout, timeout_q;
    logic [15:0]        handoff_cnt_q;

    logic [DIV_W-1:0]   rem_q, rem_next, quo_q, quo_next, dvs_q, dvs_next, rem_sub;
    logic [DIV_W:0]     rem_shift;
    logic               ge;
    logic [STEP_W-1:0]  step_q, step_next;
    logic [15:0]        result;
    logic [15:0]        freq_q, freq_next;
    logic               valid_q, valid_next, locked_q, locked_next;

    assign sample_x  = 17'(sample_in);
    assign level_set = sample_x >= HYST_HI;
    assign level_clr = sample_x <= HYST_LO;
    assign rising    = sample_valid_in && !level_q && level_set;
    assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
    assign over      = cnt_inc > 17'(MAX_COUNT);

    always_comb begin
        level_next = level_q;
        if (sample_valid_in) begin
            if (level_set)
                level_next = 1'b1;
            else if (level_clr)
                level_next = 1'b0;
        end
    end

    always_comb begin
        win_next  = win_q;
        cnt_next  = cnt_q;
        pcnt_next = pcnt_q;
        handoff   = 1'b0;
        timeout   = 1'b0;
        if (sample_valid_in) begin
            case (win_q)
                W_SEEK: begin
                    if (rising) begin
                        cnt_next  = '0;
                        pcnt_next = '0;
                        win_next  = W_COUNT;
                    end else if (over) begin
                        timeout  = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_inc[15:0];
                    end
                end
                W_COUNT: begin
                    if (over) begin
                        timeout   = 1'b1;
                        cnt_next  = '0;
                        pcnt_next = '0;
                        win_next  = W_SEEK;
                    end else if (rising && pcnt_q == PCNT_LAST) begin
                        // closing crossing doubles as the opening of the next window
                        handoff   = 1'b1;
                        cnt_next  = '0;
                        pcnt_next = '0;
                    end else begin
                        cnt_next  = cnt_inc[15:0];
                        pcnt_next = rising ? pcnt_q + 5'd1 : pcnt_q;
                    end
                end
                default: win_next = W_SEEK;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            win_q         <= W_SEEK;
            level_q       <= 1'b0;
            cnt_q         <= '0;
            pcnt_q        <= '0;
            handoff_q     <= 1'b0;
            handoff_cnt_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            win_q         <= win_next;
            level_q       <= level_next;
            cnt_q         <= cnt_next;
            pcnt_q        <= pcnt_next;
            handoff_q     <= handoff;
            handoff_cnt_q <= handoff ? cnt_inc[15:0] : handoff_cnt_q;
            timeout_q     <= timeout;
        end
    end

    assign rem_shift = {rem_q, quo_q[DIV_W-1]};
    assign ge        = rem_shift >= {1'b0, dvs_q};
    assign rem_sub   = rem_shift[DIV_W-1:0] - dvs_q;
    assign result    = (quo_q > DIV_W'(16'hFFFF)) ? 16'hFFFF : quo_q[15:0];

    always_comb begin
        div_next    = div_q;
        rem_next    = rem_q;
        quo_next    = quo_q;
        dvs_next    = dvs_q;
        step_next   = step_q;
        freq_next   = freq_q;
        valid_next  = 1'b0;
        locked_next = locked_q;
        case (div_q)
            D_IDLE: begin
                if (handoff_q) begin
                    // adding half the divisor turns the truncating divide into round-to-nearest
                    rem_next  = '0;
                    quo_next  = DIVIDEND_BASE + DIV_W'(handoff_cnt_q[15:1]);
                    dvs_next  = DIV_W'(handoff_cnt_q);
                    step_next = '0;
                    div_next  = D_BUSY;
                end
            end
            D_BUSY: begin
                rem_next  = ge ? rem_sub : rem_shift[DIV_W-1:0];
                quo_next  = {quo_q[DIV_W-2:0], ge};
                step_next = step_q + STEP_W'(1);
                if (step_q == LAST_STEP)
                    div_next = D_DONE;
            end
            D_DONE: begin
                freq_next   = result;
                valid_next  = 1'b1;
                locked_next = (result != 16'd0);
                div_next    = D_IDLE;
            end
            default: div_next = D_IDLE;
        endcase
        if (timeout_q) begin
            freq_next   = 16'd0;
            valid_next  = 1'b1;
            locked_next = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q    <= D_IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            step_q   <= '0;
            freq_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            div_q    <= div_next;
            rem_q    <= rem_next;
            quo_q    <= quo_next;
            dvs_q    <= dvs_next;
            step_q   <= step_next;
            freq_q   <= freq_next;
            valid_q  <= valid_next;
            locked_q <= locked_next;
        end
    end

    assign frequency_out  = freq_q;
    assign freq_valid_out = valid_q;
    assign locked_out     = locked_q;

endmodule
